// File: rtl/intr85_pkg.sv
// Shared types and constants for the 8085 interrupt controller: source codes,
// restart vectors, FSM states, SIM/RIM bit positions and sampled-pin indices.
package intr85_pkg;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_TRAP = 3'd1,
    SRC_R75  = 3'd2,
    SRC_R65  = 3'd3,
    SRC_R55  = 3'd4,
    SRC_INTR = 3'd5
  } src_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    INTA = 2'd2,
    ACKD = 2'd3
  } state_t;

  localparam logic [15:0] VEC_TRAP = 16'h0024;
  localparam logic [15:0] VEC_R75  = 16'h003C;
  localparam logic [15:0] VEC_R65  = 16'h0034;
  localparam logic [15:0] VEC_R55  = 16'h002C;

  localparam int SIM_SOD = 7;
  localparam int SIM_SDE = 6;
  localparam int SIM_R75 = 4;
  localparam int SIM_MSE = 3;

  localparam int RIM_SID = 7;
  localparam int RIM_I75 = 6;
  localparam int RIM_I65 = 5;
  localparam int RIM_I55 = 4;
  localparam int RIM_IE  = 3;

  localparam int PIN_TRAP = 0;
  localparam int PIN_R75  = 1;
  localparam int PIN_R65  = 2;
  localparam int PIN_R55  = 3;
  localparam int PIN_INTR = 4;
  localparam int PIN_SID  = 5;

  // INTR and "none" have no internal restart address.
  function automatic logic [15:0] src_vec(input src_t s);
    case (s)
      SRC_TRAP: src_vec = VEC_TRAP;
      SRC_R75:  src_vec = VEC_R75;
      SRC_R65:  src_vec = VEC_R65;
      SRC_R55:  src_vec = VEC_R55;
      default:  src_vec = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/edge_latch85.sv
// Rising-edge set latch with synchronous clear; i_set_wins chooses whether a
// same-cycle edge beats the clear. Used for TRAP and RST7.5.
module edge_latch85
  import intr85_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  input  logic i_clr,
  input  logic i_set_wins,
  output logic o_rise,
  output logic o_latch
);

  logic r_lvl_d;
  logic r_latch;

  assign o_rise  = i_lvl & ~r_lvl_d;
  assign o_latch = r_latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl_d <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_lvl_d <= i_lvl;
      if (o_rise && (i_set_wins || !i_clr))
        r_latch <= 1'b1;
      else if (i_clr)
        r_latch <= 1'b0;
    end
  end

endmodule

// File: rtl/intr_ctrl85.sv
// 8085 interrupt arbiter/sequencer with SIM/RIM state and INTA handshake.
// Define INTR85_SYNC_EN to put a two-flop synchronizer on every pin.
module intr_ctrl85
  import intr85_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trap,
  input  logic                rst75,
  input  logic                rst65,
  input  logic                rst55,
  input  logic                intr,
  input  logic                sid,
  input  logic                inst_done,
  input  logic                ie_set,
  input  logic                ie_clr,
  input  logic                sim_wr,
  input  logic [DATASIZE-1:0] sim_data,
  input  logic                int_ack,
  input  logic                inta_done,
  output logic                int_req,
  output logic                int_ext,
  output logic [ADDRSIZE-1:0] int_vec,
  output logic [2:0]          int_src,
  output logic [DATASIZE-1:0] rim_data,
  output logic                sod
);

  logic [5:0]          w_pins;
  logic [5:0]          r_samp;
  logic [2:0]          r_mask;
  logic                r_ie, r_ie_pend, r_ie_saved, r_show_saved, r_sod;
  state_t              r_state, w_state_nxt;
  src_t                r_src, w_src_nxt, w_win;
  logic                r_req, w_req_nxt, r_ext, w_ext_nxt;
  logic [ADDRSIZE-1:0] r_vec, w_vec_nxt;
  logic                w_trap_rise, w_trap_latch, w_r75_rise, w_r75_latch;
  logic                w_ack, w_trap_ack, w_r75_ack, w_sim_clr75;
  logic [DATASIZE-1:0] w_rim;
  logic                w_unused_sim, w_unused_r75_rise;

  assign w_pins = {sid, intr, rst55, rst65, rst75, trap};

`ifdef INTR85_SYNC_EN
  logic [5:0] r_meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_samp <= '0;
    end else begin
      r_meta <= w_pins;
      r_samp <= r_meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_samp <= '0;
    else     r_samp <= w_pins;
  end
`endif

  assign w_ack       = (r_state == REQ) && int_ack;
  assign w_trap_ack  = w_ack && (r_src == SRC_TRAP);
  assign w_r75_ack   = w_ack && (r_src == SRC_R75);
  assign w_sim_clr75 = sim_wr && sim_data[SIM_R75];

  // TRAP is level-qualified: releasing the pin forgets the edge.
  edge_latch85 u_trap (
    .clk(clk), .rst(rst), .i_lvl(r_samp[PIN_TRAP]),
    .i_clr(~r_samp[PIN_TRAP] | w_trap_ack), .i_set_wins(1'b0),
    .o_rise(w_trap_rise), .o_latch(w_trap_latch)
  );

  // A new RST7.5 edge survives a SIM reset but not its own acknowledge.
  edge_latch85 u_r75 (
    .clk(clk), .rst(rst), .i_lvl(r_samp[PIN_R75]),
    .i_clr(w_r75_ack | w_sim_clr75), .i_set_wins(~w_r75_ack),
    .o_rise(w_r75_rise), .o_latch(w_r75_latch)
  );

  always_comb begin
    w_win = SRC_NONE;
    if (w_trap_latch && r_samp[PIN_TRAP])           w_win = SRC_TRAP;
    else if (w_r75_latch && !r_mask[2] && r_ie)     w_win = SRC_R75;
    else if (r_samp[PIN_R65] && !r_mask[1] && r_ie) w_win = SRC_R65;
    else if (r_samp[PIN_R55] && !r_mask[0] && r_ie) w_win = SRC_R55;
    else if (r_samp[PIN_INTR] && r_ie)              w_win = SRC_INTR;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_src_nxt   = r_src;
    w_vec_nxt   = r_vec;
    w_ext_nxt   = r_ext;
    case (r_state)
      IDLE: if (inst_done && (w_win != SRC_NONE)) begin
        w_state_nxt = REQ;
        w_req_nxt   = 1'b1;
        w_src_nxt   = w_win;
        w_vec_nxt   = ADDRSIZE'(src_vec(w_win));
        w_ext_nxt   = (w_win == SRC_INTR);
      end
      REQ: if (int_ack) begin
        w_req_nxt   = 1'b0;
        w_state_nxt = r_ext ? INTA : ACKD;
      end else if ((r_src == SRC_TRAP) && !w_trap_latch) begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
        w_src_nxt   = SRC_NONE;
        w_vec_nxt   = '0;
        w_ext_nxt   = 1'b0;
      end else if (w_trap_rise && (r_src != SRC_TRAP)) begin
        w_src_nxt   = SRC_TRAP;
        w_vec_nxt   = ADDRSIZE'(VEC_TRAP);
        w_ext_nxt   = 1'b0;
      end
      INTA: if (inta_done) w_state_nxt = ACKD;
      ACKD: begin
        w_state_nxt = IDLE;
        w_src_nxt   = SRC_NONE;
        w_vec_nxt   = '0;
        w_ext_nxt   = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_src   <= SRC_NONE;
      r_vec   <= '0;
      r_ext   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_src   <= w_src_nxt;
      r_vec   <= w_vec_nxt;
      r_ext   <= w_ext_nxt;
    end
  end

  // EI takes effect one instruction late; DI and acknowledge act immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask       <= 3'b111;
      r_sod        <= 1'b0;
      r_ie         <= 1'b0;
      r_ie_pend    <= 1'b0;
      r_ie_saved   <= 1'b0;
      r_show_saved <= 1'b0;
    end else begin
      if (sim_wr && sim_data[SIM_MSE]) r_mask <= sim_data[2:0];
      if (sim_wr && sim_data[SIM_SDE]) r_sod  <= sim_data[SIM_SOD];
      if (ie_clr) begin
        r_ie      <= 1'b0;
        r_ie_pend <= 1'b0;
      end else begin
        if (inst_done && r_ie_pend) begin
          r_ie      <= 1'b1;
          r_ie_pend <= 1'b0;
        end
        if (ie_set) r_ie_pend <= 1'b1;
      end
      if (w_ack) r_ie <= 1'b0;
      if (w_trap_ack) begin
        r_ie_saved   <= r_ie;
        r_show_saved <= 1'b1;
      end else if (ie_set || ie_clr) begin
        r_show_saved <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rim          = '0;
    w_rim[RIM_SID] = r_samp[PIN_SID];
    w_rim[RIM_I75] = w_r75_latch;
    w_rim[RIM_I65] = r_samp[PIN_R65];
    w_rim[RIM_I55] = r_samp[PIN_R55];
    w_rim[RIM_IE]  = r_show_saved ? r_ie_saved : r_ie;
    w_rim[2:0]     = r_mask;
  end

  assign w_unused_sim      = ^sim_data;
  assign w_unused_r75_rise = w_r75_rise;

  assign int_req  = r_req;
  assign int_ext  = r_ext;
  assign int_vec  = r_vec;
  assign int_src  = r_src;
  assign rim_data = w_rim;
  assign sod      = r_sod;

endmodule

// File: tb/tb_intr_ctrl85.sv
// Scenario bench for intr_ctrl85: expected requests are queued when stimulus
// is applied and compared when int_req rises.
module tb_intr_ctrl85;

  typedef struct {
    logic [2:0]  src;
    logic [15:0] vec;
    logic        ext;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trap = 1'b0, rst75 = 1'b0, rst65 = 1'b0, rst55 = 1'b0;
  logic        intr = 1'b0, sid = 1'b0;
  logic        inst_done = 1'b0, ie_set = 1'b0, ie_clr = 1'b0;
  logic        sim_wr = 1'b0;
  logic [7:0]  sim_data = 8'h00;
  logic        int_ack = 1'b0, inta_done = 1'b0;
  logic        int_req, int_ext, sod;
  logic [15:0] int_vec;
  logic [2:0]  int_src;
  logic [7:0]  rim_data;

  always #5 clk = ~clk;

  intr_ctrl85 #(.DATASIZE(8), .ADDRSIZE(16)) dut (
    .clk(clk), .rst(rst), .trap(trap), .rst75(rst75), .rst65(rst65),
    .rst55(rst55), .intr(intr), .sid(sid), .inst_done(inst_done),
    .ie_set(ie_set), .ie_clr(ie_clr), .sim_wr(sim_wr), .sim_data(sim_data),
    .int_ack(int_ack), .inta_done(inta_done), .int_req(int_req),
    .int_ext(int_ext), .int_vec(int_vec), .int_src(int_src),
    .rim_data(rim_data), .sod(sod)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic sim_write(input logic [7:0] d);
    sim_wr = 1'b1; sim_data = d; tick(); sim_wr = 1'b0; sim_data = 8'h00;
  endtask

  task automatic pulse_inst();
    inst_done = 1'b1; tick(); inst_done = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic enable_ie();
    ie_set = 1'b1; tick(); ie_set = 1'b0;
    pulse_inst();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (int_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    checks++;
    if (int_req !== 1'b0 || int_ext !== 1'b0 || int_vec !== 16'h0 || int_src !== 3'd0 || sod !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs req=%b ext=%b vec=%h src=%0d sod=%b, required all zero", int_req, int_ext, int_vec, int_src, sod);
    end
    checks++;
    if (rim_data !== 8'h07) begin
      errors++;
      $display("FAIL reset_rim got %h required 07", rim_data);
    end
  endtask

  task automatic test_r75();
    exp_t e; bit ok;
    sim_write(8'h08);
    enable_ie();
    checks++;
    if (rim_data !== 8'h08) begin
      errors++;
      $display("FAIL rim_after_ei got %h required 08", rim_data);
    end
    rst75 = 1'b1; repeat (3) tick(); rst75 = 1'b0; settle();
    checks++;
    if (rim_data !== 8'h48) begin
      errors++;
      $display("FAIL rim_r75_pending got %h required 48", rim_data);
    end
    sb_q.push_back('{src: 3'd2, vec: 16'h003C, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec || int_ext !== e.ext) begin
      errors++;
      $display("FAIL r75_req req=%b src=%0d vec=%h ext=%b required 1 %0d %h %b", int_req, int_src, int_vec, int_ext, e.src, e.vec, e.ext);
    end
    pulse_ack();
    checks++;
    if (int_req !== 1'b0 || rim_data !== 8'h00) begin
      errors++;
      $display("FAIL r75_ack req=%b rim=%h required 0 00", int_req, rim_data);
    end
    tick();
    checks++;
    if (int_src !== 3'd0) begin
      errors++;
      $display("FAIL r75_src_clear got %0d required 0", int_src);
    end
  endtask

  task automatic test_priority();
    exp_t e; bit ok;
    rst65 = 1'b1; rst55 = 1'b1; settle();
    enable_ie();
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL ei_delay req=%b required 0", int_req);
    end
    sb_q.push_back('{src: 3'd3, vec: 16'h0034, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec || int_ext !== e.ext) begin
      errors++;
      $display("FAIL r65_wins req=%b src=%0d vec=%h required 1 %0d %h", int_req, int_src, int_vec, e.src, e.vec);
    end
    pulse_ack(); tick();
    rst65 = 1'b0; settle();
    enable_ie();
    sb_q.push_back('{src: 3'd4, vec: 16'h002C, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec || int_ext !== e.ext) begin
      errors++;
      $display("FAIL r55_next req=%b src=%0d vec=%h required 1 %0d %h", int_req, int_src, int_vec, e.src, e.vec);
    end
    pulse_ack(); tick();
    rst55 = 1'b0; settle();
  endtask

  task automatic test_trap();
    exp_t e; bit ok;
    enable_ie();
    trap = 1'b1; settle();
    sb_q.push_back('{src: 3'd1, vec: 16'h0024, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec || int_ext !== e.ext) begin
      errors++;
      $display("FAIL trap_req req=%b src=%0d vec=%h required 1 %0d %h", int_req, int_src, int_vec, e.src, e.vec);
    end
    pulse_ack();
    checks++;
    if (int_req !== 1'b0 || rim_data[3] !== 1'b1) begin
      errors++;
      $display("FAIL trap_ie_saved req=%b rim3=%b required 0 1", int_req, rim_data[3]);
    end
    tick();
    ie_clr = 1'b1; tick(); ie_clr = 1'b0;
    checks++;
    if (rim_data[3] !== 1'b0) begin
      errors++;
      $display("FAIL trap_ie_clr rim3=%b required 0", rim_data[3]);
    end
    trap = 1'b0; settle();
    trap = 1'b1; settle();
    sb_q.push_back('{src: 3'd1, vec: 16'h0024, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec) begin
      errors++;
      $display("FAIL trap_req2 req=%b src=%0d vec=%h required 1 %0d %h", int_req, int_src, int_vec, e.src, e.vec);
    end
    trap = 1'b0;
    for (int i = 0; i < 8 && int_req === 1'b1; i++) tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_release req=%b required 0", int_req);
    end
    settle();
  endtask

  task automatic test_trap_preempt();
    exp_t e; bit ok; bit dropped;
    enable_ie();
    rst55 = 1'b1; settle();
    sb_q.push_back('{src: 3'd4, vec: 16'h002C, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec) begin
      errors++;
      $display("FAIL preempt_first req=%b src=%0d vec=%h required 1 %0d %h", int_req, int_src, int_vec, e.src, e.vec);
    end
    trap = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 8 && int_src !== 3'd1; i++) begin
      tick();
      if (int_req !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped || int_req !== 1'b1 || int_src !== 3'd1 || int_vec !== 16'h0024) begin
      errors++;
      $display("FAIL trap_preempt dropped=%b req=%b src=%0d vec=%h required 0 1 1 0024", dropped, int_req, int_src, int_vec);
    end
    pulse_ack(); tick();
    ie_clr = 1'b1; tick(); ie_clr = 1'b0;
    trap = 1'b0; rst55 = 1'b0; settle();
  endtask

  task automatic test_intr();
    exp_t e; bit ok;
    enable_ie();
    intr = 1'b1; settle();
    sb_q.push_back('{src: 3'd5, vec: 16'h0000, ext: 1'b1});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || int_vec !== e.vec || int_ext !== e.ext) begin
      errors++;
      $display("FAIL intr_req req=%b src=%0d vec=%h ext=%b required 1 %0d %h %b", int_req, int_src, int_vec, int_ext, e.src, e.vec, e.ext);
    end
    pulse_ack();
    intr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (int_req !== 1'b0 || int_src !== 3'd5) begin
        errors++;
        $display("FAIL inta_hold cycle=%0d req=%b src=%0d required 0 5", i, int_req, int_src);
      end
      tick();
    end
    inta_done = 1'b1; tick(); inta_done = 1'b0;
    tick();
    checks++;
    if (int_src !== 3'd0 || int_ext !== 1'b0) begin
      errors++;
      $display("FAIL inta_done_src src=%0d ext=%b required 0 0", int_src, int_ext);
    end
  endtask

  task automatic test_sim_rim();
    sim_write(8'h0C);
    rst75 = 1'b1; repeat (3) tick(); rst75 = 1'b0; settle();
    checks++;
    if (rim_data !== 8'h44) begin
      errors++;
      $display("FAIL rim_masked_r75 got %h required 44", rim_data);
    end
    pulse_inst(); tick();
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL masked_no_req req=%b required 0", int_req);
    end
    sim_write(8'h10);
    checks++;
    if (rim_data !== 8'h04) begin
      errors++;
      $display("FAIL sim_r75_reset rim=%h required 04", rim_data);
    end
    sim_write(8'hC0);
    checks++;
    if (sod !== 1'b1 || rim_data[2:0] !== 3'b100) begin
      errors++;
      $display("FAIL sod_set sod=%b masks=%b required 1 100", sod, rim_data[2:0]);
    end
    sim_write(8'h40);
    checks++;
    if (sod !== 1'b0) begin
      errors++;
      $display("FAIL sod_clr sod=%b required 0", sod);
    end
    sid = 1'b1; settle();
    checks++;
    if (rim_data[7] !== 1'b1) begin
      errors++;
      $display("FAIL rim_sid got %b required 1", rim_data[7]);
    end
    sid = 1'b0; settle();
  endtask

  task automatic test_reset_in_req();
    exp_t e; bit ok;
    rst55 = 1'b1;
    sim_write(8'hC8);
    settle();
    enable_ie();
    sb_q.push_back('{src: 3'd4, vec: 16'h002C, ext: 1'b0});
    pulse_inst();
    wait_req(ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || int_src !== e.src || sod !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req req=%b src=%0d sod=%b required 1 %0d 1", int_req, int_src, sod, e.src);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (int_req !== 1'b0 || rim_data[2:0] !== 3'b111 || rim_data[3] !== 1'b0 || sod !== 1'b0 || int_src !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_req req=%b masks=%b ie=%b sod=%b src=%0d required 0 111 0 0 0", int_req, rim_data[2:0], rim_data[3], sod, int_src);
    end
    rst55 = 1'b0; settle();
  endtask

  initial begin
    tick();
    test_reset();
    test_r75();
    test_priority();
    test_trap();
    test_trap_preempt();
    test_intr();
    test_sim_rim();
    test_reset_in_req();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
